// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES equal chunks,
// one registered chunk per stage, with valid/ready flow control on both sides.
module pipe_adder #(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int USE_CIN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SDIV  = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = WIDTH / SDIV;
  localparam int OW    = (STAGES > 1) ? WIDTH - CHUNK : 1;
  localparam int NOP   = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || WIDTH < 1 || (WIDTH % SDIV) != 0) begin : g_param_check
    $error("pipe_adder: WIDTH must be a positive multiple of STAGES, STAGES >= 1");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  sm  [STAGES];
  logic              cr  [STAGES];
  // Unprocessed upper operand chunks, shifted down so the next chunk sits at bit 0.
  logic [OW-1:0]     opa [NOP];
  logic [OW-1:0]     opb [NOP];

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign sum       = sm[STAGES-1];
  assign cout      = cr[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             up_v;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             ci;
    logic [WIDTH-1:0] up_sum;
    logic [CHUNK:0]   add;

    // Closed form of ready_k = !valid_k || ready_(k+1): stage k can load
    // unless it and every stage after it are full and the output is stalled.
    assign rdy[k] = out_ready || !(&vld[STAGES-1:k]);

    if (k == 0) begin : g_first
      assign up_v   = in_valid;
      assign ca     = a[CHUNK-1:0];
      assign cb     = b[CHUNK-1:0];
      assign ci     = (USE_CIN != 0) ? cin : 1'b0;
      assign up_sum = '0;
    end else begin : g_rest
      assign up_v   = vld[k-1];
      assign ca     = opa[k-1][CHUNK-1:0];
      assign cb     = opb[k-1][CHUNK-1:0];
      assign ci     = cr[k-1];
      assign up_sum = sm[k-1];
    end

    assign add = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, ci};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld[k] <= 1'b0;
        sm[k]  <= '0;
        cr[k]  <= 1'b0;
      end else if (rdy[k]) begin
        vld[k] <= up_v;
        sm[k]  <= up_sum | (WIDTH'(add[CHUNK-1:0]) << (k * CHUNK));
        cr[k]  <= add[CHUNK];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OW-1:0] nxt_a;
      logic [OW-1:0] nxt_b;

      if (k == 0) begin : g_src_in
        assign nxt_a = a[WIDTH-1:CHUNK];
        assign nxt_b = b[WIDTH-1:CHUNK];
      end else begin : g_src_pipe
        assign nxt_a = opa[k-1] >> CHUNK;
        assign nxt_b = opb[k-1] >> CHUNK;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opa[k] <= '0;
          opb[k] <= '0;
        end else if (rdy[k]) begin
          opa[k] <= nxt_a;
          opb[k] <= nxt_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: a full-adder and a half-adder instance
// (WIDTH=8, STAGES=2) driven from shared stimulus.
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       fa_ir, fa_ov, fa_co;
  logic       ha_ir, ha_ov, ha_co;
  logic [7:0] fa_s, ha_s;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .STAGES(2), .USE_CIN(1)) u_fa (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fa_ir),
    .a(a), .b(b), .cin(cin), .out_valid(fa_ov), .out_ready(out_ready),
    .sum(fa_s), .cout(fa_co)
  );

  pipe_adder #(.WIDTH(8), .STAGES(2), .USE_CIN(0)) u_ha (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ha_ir),
    .a(a), .b(b), .cin(cin), .out_valid(ha_ov), .out_ready(out_ready),
    .sum(ha_s), .cout(ha_co)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc);
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if ({fa_ov, fa_co, fa_s, fa_ir} !== 11'h001) begin
      nmis++;
      $display("FAIL reset_fa: got %h expected %h", {fa_ov, fa_co, fa_s, fa_ir}, 11'h001);
    end
    nvec++;
    if ({ha_ov, ha_co, ha_s, ha_ir} !== 11'h001) begin
      nmis++;
      $display("FAIL reset_ha: got %h expected %h", {ha_ov, ha_co, ha_s, ha_ir}, 11'h001);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    nvec++;
    if ({fa_ov, ha_ov, fa_ir, ha_ir} !== 4'b0011) begin
      nmis++;
      $display("FAIL after_reset_idle: got %b expected %b", {fa_ov, ha_ov, fa_ir, ha_ir}, 4'b0011);
    end
  endtask

  task automatic test_full_adder();
    logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'h0F};
    logic [7:0] tb [3] = '{8'h01, 8'h00, 8'h01};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [9:0] efa[3] = '{10'h300, 10'h280, 10'h210};
    logic [9:0] eha[3] = '{10'h300, 10'h27F, 10'h210};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, ta[i], tb[i], tc[i]);
      tick();
      put(1'b0, 8'h00, 8'h00, 1'b0);
      nvec++;
      if (fa_ov !== 1'b0) begin
        nmis++;
        $display("FAIL fa_latency_%0d: out_valid got %b expected 0", i, fa_ov);
      end
      tick();
      nvec++;
      if ({fa_ov, fa_co, fa_s} !== efa[i]) begin
        nmis++;
        $display("FAIL fa_add_%0d: got %h expected %h", i, {fa_ov, fa_co, fa_s}, efa[i]);
      end
      nvec++;
      if ({ha_ov, ha_co, ha_s} !== eha[i]) begin
        nmis++;
        $display("FAIL ha_shadow_%0d: got %h expected %h", i, {ha_ov, ha_co, ha_s}, eha[i]);
      end
      tick();
    end
  endtask

  task automatic test_half_adder();
    logic [7:0] ta [2] = '{8'h01, 8'h80};
    logic [7:0] tb [2] = '{8'h01, 8'h80};
    logic [9:0] efa[2] = '{10'h203, 10'h301};
    logic [9:0] eha[2] = '{10'h202, 10'h300};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      put(1'b1, ta[i], tb[i], 1'b1);
      tick();
      put(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      nvec++;
      if ({ha_ov, ha_co, ha_s} !== eha[i]) begin
        nmis++;
        $display("FAIL ha_add_%0d: got %h expected %h", i, {ha_ov, ha_co, ha_s}, eha[i]);
      end
      nvec++;
      if ({fa_ov, fa_co, fa_s} !== efa[i]) begin
        nmis++;
        $display("FAIL fa_cin_%0d: got %h expected %h", i, {fa_ov, fa_co, fa_s}, efa[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [4] = '{8'h01, 8'h02, 8'h03, 8'hFF};
    logic [9:0] exp_r [4] = '{10'h202, 10'h204, 10'h206, 10'h3FE};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) put(1'b1, ops[i], ops[i], 1'b0);
      else       put(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      if (i >= 1 && i <= 4) begin
        nvec++;
        if ({fa_ov, fa_co, fa_s} !== exp_r[i-1]) begin
          nmis++;
          $display("FAIL stream_%0d: got %h expected %h", i - 1, {fa_ov, fa_co, fa_s}, exp_r[i-1]);
        end
      end else if (i == 5) begin
        nvec++;
        if (fa_ov !== 1'b0) begin
          nmis++;
          $display("FAIL stream_end: out_valid got %b expected 0", fa_ov);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    put(1'b1, 8'h10, 8'h01, 1'b0);
    tick();
    nvec++;
    if ({fa_ov, fa_ir} !== 2'b01) begin
      nmis++;
      $display("FAIL bp_first_accept: {ov,ir} got %b expected 01", {fa_ov, fa_ir});
    end
    put(1'b1, 8'h20, 8'h02, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      // Junk on the operand bus while full must not be captured.
      put(1'b1, 8'hFF, 8'hFF, 1'b1);
      nvec++;
      if ({fa_ov, fa_co, fa_s, fa_ir} !== 11'h422) begin
        nmis++;
        $display("FAIL bp_stall_%0d: {ov,co,sum,ir} got %h expected %h", i,
                 {fa_ov, fa_co, fa_s, fa_ir}, 11'h422);
      end
      tick();
    end
    put(1'b1, 8'h30, 8'h03, 1'b0);
    out_ready = 1'b1;
    #1;
    nvec++;
    if (fa_ir !== 1'b1) begin
      nmis++;
      $display("FAIL bp_release_ready: in_ready got %b expected 1", fa_ir);
    end
    tick();
    put(1'b0, 8'h00, 8'h00, 1'b0);
    nvec++;
    if ({fa_ov, fa_co, fa_s} !== 10'h222) begin
      nmis++;
      $display("FAIL bp_drain_1: got %h expected %h", {fa_ov, fa_co, fa_s}, 10'h222);
    end
    tick();
    nvec++;
    if ({fa_ov, fa_co, fa_s} !== 10'h233) begin
      nmis++;
      $display("FAIL bp_drain_2: got %h expected %h", {fa_ov, fa_co, fa_s}, 10'h233);
    end
    tick();
    nvec++;
    if (fa_ov !== 1'b0) begin
      nmis++;
      $display("FAIL bp_drain_empty: out_valid got %b expected 0", fa_ov);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    put(1'b1, 8'h11, 8'h11, 1'b0);
    tick();
    put(1'b1, 8'h22, 8'h22, 1'b0);
    tick();
    put(1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if ({fa_ov, fa_co, fa_s, fa_ir} !== 11'h001) begin
      nmis++;
      $display("FAIL rst_async: {ov,co,sum,ir} got %h expected %h", {fa_ov, fa_co, fa_s, fa_ir}, 11'h001);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (fa_ov !== 1'b0) begin
        nmis++;
        $display("FAIL rst_no_stale_%0d: out_valid got %b expected 0", i, fa_ov);
      end
    end
    put(1'b1, 8'h05, 8'h03, 1'b0);
    tick();
    put(1'b0, 8'h00, 8'h00, 1'b0);
    nvec++;
    if (fa_ov !== 1'b0) begin
      nmis++;
      $display("FAIL rst_post_latency: out_valid got %b expected 0", fa_ov);
    end
    tick();
    nvec++;
    if ({fa_ov, fa_co, fa_s} !== 10'h208) begin
      nmis++;
      $display("FAIL rst_post_add: got %h expected %h", {fa_ov, fa_co, fa_s}, 10'h208);
    end
  endtask

  initial begin
    test_reset();
    test_full_adder();
    test_half_adder();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
